// File: rtl/dds_multichannel_core.sv
// Time-multiplexed multichannel DDS core.
// One sample_tick runs a frame that steps every channel through
// ACC (phase += tuning) -> WAVE (shape lookup) -> SCALE (amplitude) -> SEND (handshake).
// Per-channel shadow registers are written by the config port and copied to the
// active set when a frame starts, so a frame always uses one consistent set of settings.
// Optional feature: define DDS_OFFSET_EN to add a per-channel saturating output offset
// (cfg_addr 3). Without it there is no offset storage or adder, and cfg_addr 3 writes are ignored.
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   sample_tick      starts a frame when idle; raises overrun when busy
//   cfg_we/ch/addr/data  shadow register write (0 tuning, 1 amp, 2 shape, 3 offset)
//   out_valid/ready/data/ch  sample stream, one sample per channel per frame
//   busy             high while a frame is running
//   overrun          one-cycle pulse for each dropped sample_tick
module dds_multichannel_core #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned OUT_W    = 12,
  parameter int unsigned AMP_W    = 12,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [CW-1:0]      cfg_ch,
  input  logic [1:0]         cfg_addr,
  input  logic [PHASE_W-1:0] cfg_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CW-1:0]      out_ch,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned PROD_W = OUT_W + AMP_W;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  typedef enum logic [2:0] {IDLE, ACC, WAVE, SCALE, SEND} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            commit_c;
  logic            overrun_c;
  logic            cfg_hit_c;

  logic [PHASE_W-1:0] phase_q  [CHANNELS];
  logic [PHASE_W-1:0] sh_tune  [CHANNELS];
  logic [AMP_W-1:0]   sh_amp   [CHANNELS];
  logic [1:0]         sh_shape [CHANNELS];
  logic [PHASE_W-1:0] ac_tune  [CHANNELS];
  logic [AMP_W-1:0]   ac_amp   [CHANNELS];
  logic [1:0]         ac_shape [CHANNELS];
`ifdef DDS_OFFSET_EN
  localparam int unsigned SUM_W = OUT_W + 1;
  logic [OUT_W-1:0]   sh_off   [CHANNELS];
  logic [OUT_W-1:0]   ac_off   [CHANNELS];
  logic [SUM_W-1:0]   sum_c;
`endif

  logic [OUT_W-1:0]  wave_c, wave_q;
  logic [PROD_W-1:0] prod_c;
  logic [OUT_W-1:0]  scaled_c;
  logic [OUT_W-1:0]  result_c;

  // Next-state logic: frame sequencing and channel stepping
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    commit_c  = 1'b0;
    overrun_c = sample_tick && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d  = ACC;
          commit_c = 1'b1;
        end
      end
      ACC:   state_d = WAVE;
      WAVE:  state_d = SCALE;
      SCALE: state_d = SEND;
      SEND: begin
        if (out_ready) begin
          if (ch_q == LAST_CH) begin
            state_d = IDLE;
            ch_d    = '0;
          end else begin
            state_d = ACC;
            ch_d    = ch_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; busy/out_valid are registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == SEND);
      overrun   <= overrun_c;
    end
  end

  assign cfg_hit_c = cfg_we && (32'(cfg_ch) < CHANNELS);

  // Shadow registers, written by the config port at any time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sh_tune[i]  <= '0;
        sh_amp[i]   <= '0;
        sh_shape[i] <= '0;
`ifdef DDS_OFFSET_EN
        sh_off[i]   <= '0;
`endif
      end
    end else if (cfg_hit_c) begin
      case (cfg_addr)
        2'd0: sh_tune[cfg_ch]  <= cfg_data;
        2'd1: sh_amp[cfg_ch]   <= cfg_data[AMP_W-1:0];
        2'd2: sh_shape[cfg_ch] <= cfg_data[1:0];
        2'd3: begin
`ifdef DDS_OFFSET_EN
          sh_off[cfg_ch] <= cfg_data[OUT_W-1:0];
`endif
        end
      endcase
    end
  end

  // Active registers take the pre-edge shadow values when a frame starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ac_tune[i]  <= '0;
        ac_amp[i]   <= '0;
        ac_shape[i] <= '0;
`ifdef DDS_OFFSET_EN
        ac_off[i]   <= '0;
`endif
      end
    end else if (commit_c) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ac_tune[i]  <= sh_tune[i];
        ac_amp[i]   <= sh_amp[i];
        ac_shape[i] <= sh_shape[i];
`ifdef DDS_OFFSET_EN
        ac_off[i]   <= sh_off[i];
`endif
      end
    end
  end

  // Phase accumulators, wrapping modulo 2^PHASE_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) phase_q[i] <= '0;
    end else if (state_q == ACC) begin
      phase_q[ch_q] <= phase_q[ch_q] + ac_tune[ch_q];
    end
  end

  // Waveform lookup from the freshly updated phase
  always_comb begin
    wave_c = '0;
    case (ac_shape[ch_q])
      2'd0: wave_c = phase_q[ch_q][PHASE_W-1 -: OUT_W];
      2'd1: wave_c = phase_q[ch_q][PHASE_W-1] ? ~phase_q[ch_q][PHASE_W-2 -: OUT_W]
                                               :  phase_q[ch_q][PHASE_W-2 -: OUT_W];
      2'd2: wave_c = phase_q[ch_q][PHASE_W-1] ? '0 : '1;
      2'd3: wave_c = OUT_W'(1) << (OUT_W - 1);
    endcase
  end

  // Amplitude scaling; wave < 2^OUT_W so the shifted product always fits OUT_W
  assign prod_c   = PROD_W'(wave_q) * PROD_W'(ac_amp[ch_q]);
  assign scaled_c = OUT_W'(prod_c >> AMP_W);

`ifdef DDS_OFFSET_EN
  // Saturating offset add
  assign sum_c    = SUM_W'(scaled_c) + SUM_W'(ac_off[ch_q]);
  assign result_c = sum_c[OUT_W] ? '1 : sum_c[OUT_W-1:0];
`else
  assign result_c = scaled_c;
`endif

  // Datapath pipeline registers; out_data/out_ch only load on the way into SEND
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wave_q   <= '0;
      out_data <= '0;
      out_ch   <= '0;
    end else begin
      if (state_q == WAVE) wave_q <= wave_c;
      if (state_q == SCALE) begin
        out_data <= result_c;
        out_ch   <= ch_q;
      end
    end
  end

endmodule

// File: tb/tb_dds_multichannel_core.sv
// Directed testbench for dds_multichannel_core (CHANNELS=4, PHASE_W=24, OUT_W=12, AMP_W=12).
module tb_dds_multichannel_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [1:0]  out_ch;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  // Per-frame capture
  logic [11:0] fr_data [4];
  logic [1:0]  fr_ch   [4];
  int          fr_lat  [4];
  int          fr_n;
  int          idle_at;
  int          ovr_cnt;
  int          ovr_first;
  logic        busy0;
  logic [1:0]  inj_ch;
  logic [1:0]  inj_addr;
  logic [23:0] inj_data;

  dds_multichannel_core #(
    .CHANNELS(4), .PHASE_W(24), .OUT_W(12), .AMP_W(12)
  ) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] c, input logic [1:0] a, input logic [23:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = c; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Pulse a tick and record every sample of the frame. Negedge index i counts from the
  // negedge right after the tick edge (index 0). inject_at>=1 drives a second tick plus
  // the inj_* config write at that index; inject_at==0 drives the write with the tick.
  task automatic run_frame(input int inject_at);
    fr_n = 0; idle_at = -1; ovr_cnt = 0; ovr_first = -1;
    @(negedge clk);
    sample_tick = 1'b1;
    if (inject_at == 0) begin
      cfg_we = 1'b1; cfg_ch = inj_ch; cfg_addr = inj_addr; cfg_data = inj_data;
    end
    @(negedge clk);
    sample_tick = 1'b0; cfg_we = 1'b0;
    busy0 = busy;
    for (int i = 1; i <= 200 && idle_at < 0; i++) begin
      @(negedge clk);
      if (overrun) begin
        ovr_cnt++;
        if (ovr_first < 0) ovr_first = i;
      end
      if (out_valid && out_ready && fr_n < 4) begin
        fr_data[fr_n] = out_data; fr_ch[fr_n] = out_ch; fr_lat[fr_n] = i;
        fr_n++;
      end
      if (fr_n == 4 && !busy) idle_at = i;
      sample_tick = 1'b0; cfg_we = 1'b0;
      if (i == inject_at) begin
        sample_tick = 1'b1;
        cfg_we = 1'b1; cfg_ch = inj_ch; cfg_addr = inj_addr; cfg_data = inj_data;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, busy, overrun, out_ch, out_data} !== 17'd0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", {out_valid, busy, overrun, out_ch, out_data});
    end
    @(negedge clk); rst = 1'b1;
    cfg_write(2'd0, 2'd0, 24'h100000);
    cfg_write(2'd0, 2'd1, 24'h000FFF);
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_data} !== {1'b1, 12'h0FF}) begin
      bad++; $display("FAIL reset_pre_send got=%h exp=%h", {out_valid, out_data}, {1'b1, 12'h0FF});
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, out_data, out_ch} !== 16'd0) begin
      bad++; $display("FAIL reset_midframe got=%h exp=0", {out_valid, busy, out_data, out_ch});
    end
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL reset_no_resume got=%0d exp=0", seen);
    end
    // Shadow registers were cleared too, so a fresh frame emits zeros
    run_frame(-1);
    total++;
    if (fr_n !== 4) begin bad++; $display("FAIL reset_fresh_count got=%0d exp=4", fr_n); end
    total++;
    if (fr_data[0] !== 12'h000) begin bad++; $display("FAIL reset_fresh_ch0 got=%h exp=000", fr_data[0]); end
  endtask

  task automatic test_saw();
    apply_reset();
    cfg_write(2'd0, 2'd0, 24'h100000);
    cfg_write(2'd0, 2'd1, 24'h000FFF);
    run_frame(-1);
    total++; if (fr_n !== 4) begin bad++; $display("FAIL saw_count got=%0d exp=4", fr_n); end
    total++; if (fr_data[0] !== 12'h0FF) begin bad++; $display("FAIL saw_f1 got=%h exp=0ff", fr_data[0]); end
    total++; if (fr_ch[0] !== 2'd0) begin bad++; $display("FAIL saw_ch0 got=%0d exp=0", fr_ch[0]); end
    total++; if (fr_lat[0] !== 3) begin bad++; $display("FAIL saw_lat0 got=%0d exp=3", fr_lat[0]); end
    total++; if (fr_lat[1] !== 7) begin bad++; $display("FAIL saw_lat1 got=%0d exp=7", fr_lat[1]); end
    total++; if (fr_lat[3] !== 15) begin bad++; $display("FAIL saw_lat3 got=%0d exp=15", fr_lat[3]); end
    total++; if (fr_ch[3] !== 2'd3) begin bad++; $display("FAIL saw_ch3 got=%0d exp=3", fr_ch[3]); end
    total++; if (fr_data[1] !== 12'h000) begin bad++; $display("FAIL saw_ch1_zero_amp got=%h exp=000", fr_data[1]); end
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL saw_busy got=%b exp=1", busy0); end
    total++; if (idle_at !== 16) begin bad++; $display("FAIL saw_frame_len got=%0d exp=16", idle_at); end
    total++; if (ovr_cnt !== 0) begin bad++; $display("FAIL saw_no_overrun got=%0d exp=0", ovr_cnt); end
    run_frame(-1);
    total++; if (fr_data[0] !== 12'h1FF) begin bad++; $display("FAIL saw_f2 got=%h exp=1ff", fr_data[0]); end
    repeat (13) run_frame(-1);
    // Phase 0xF00000 -> 0xF00 * 0xFFF >> 12
    total++; if (fr_data[0] !== 12'hEFF) begin bad++; $display("FAIL saw_f15 got=%h exp=eff", fr_data[0]); end
    run_frame(-1);
    total++; if (fr_data[0] !== 12'h000) begin bad++; $display("FAIL saw_wrap got=%h exp=000", fr_data[0]); end
  endtask

  task automatic test_square();
    apply_reset();
    cfg_write(2'd1, 2'd2, 24'd2);
    cfg_write(2'd1, 2'd0, 24'h800000);
    cfg_write(2'd1, 2'd1, 24'h000800);
    // Phase 0x800000 (MSB set) -> low half of the square
    run_frame(-1);
    total++; if (fr_data[1] !== 12'h000) begin bad++; $display("FAIL sq_f1 got=%h exp=000", fr_data[1]); end
    total++; if (fr_ch[1] !== 2'd1) begin bad++; $display("FAIL sq_ch got=%0d exp=1", fr_ch[1]); end
    total++; if (fr_lat[1] !== 7) begin bad++; $display("FAIL sq_lat got=%0d exp=7", fr_lat[1]); end
    // Phase wraps to 0 -> 0xFFF * 0x800 >> 12
    run_frame(-1);
    total++; if (fr_data[1] !== 12'h7FF) begin bad++; $display("FAIL sq_f2 got=%h exp=7ff", fr_data[1]); end
  endtask

  task automatic test_shapes();
    apply_reset();
    cfg_write(2'd2, 2'd2, 24'd1);
    cfg_write(2'd2, 2'd0, 24'hC00000);
    cfg_write(2'd2, 2'd1, 24'h000FFF);
    cfg_write(2'd3, 2'd2, 24'd3);
    cfg_write(2'd3, 2'd0, 24'h123456);
    cfg_write(2'd3, 2'd1, 24'h000FFF);
    // Triangle phase 0xC00000: ~0x800 = 0x7FF, *0xFFF >> 12 = 0x7FE; DC 0x800 -> 0x7FF
    run_frame(-1);
    total++; if (fr_data[2] !== 12'h7FE) begin bad++; $display("FAIL tri_f1 got=%h exp=7fe", fr_data[2]); end
    total++; if (fr_data[3] !== 12'h7FF) begin bad++; $display("FAIL dc_f1 got=%h exp=7ff", fr_data[3]); end
    // Triangle phase 0x800000: ~0x000 = 0xFFF -> 0xFFE
    run_frame(-1);
    total++; if (fr_data[2] !== 12'hFFE) begin bad++; $display("FAIL tri_f2 got=%h exp=ffe", fr_data[2]); end
  endtask

  task automatic test_backpressure();
    int lat;
    apply_reset();
    cfg_write(2'd0, 2'd0, 24'h100000);
    cfg_write(2'd0, 2'd1, 24'h000FFF);
    @(negedge clk); out_ready = 1'b0; sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    total++; if (lat !== 3) begin bad++; $display("FAIL bp_first_valid got=%0d exp=3", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, busy, out_ch, out_data} !== {1'b1, 1'b1, 2'd0, 12'h0FF}) begin
        bad++; $display("FAIL bp_hold%0d got=%h exp=%h", i, {out_valid, busy, out_ch, out_data},
                        {1'b1, 1'b1, 2'd0, 12'h0FF});
      end
    end
    out_ready = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid && out_ch == 2'd1) lat = i;
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL bp_ch1_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", busy); end
  endtask

  task automatic test_overrun();
    apply_reset();
    cfg_write(2'd0, 2'd0, 24'h100000);
    cfg_write(2'd0, 2'd1, 24'h000FFF);
    cfg_write(2'd3, 2'd0, 24'h100000);
    cfg_write(2'd3, 2'd1, 24'h000FFF);
    inj_ch = 2'd3; inj_addr = 2'd0; inj_data = 24'h300000;
    run_frame(4);
    total++; if (ovr_cnt !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt); end
    total++; if (ovr_first !== 5) begin bad++; $display("FAIL ovr_when got=%0d exp=5", ovr_first); end
    total++; if (fr_n !== 4) begin bad++; $display("FAIL ovr_count got=%0d exp=4", fr_n); end
    total++; if (fr_data[3] !== 12'h0FF) begin bad++; $display("FAIL ovr_ch3_f1 got=%h exp=0ff", fr_data[3]); end
    total++; if (fr_lat[3] !== 15) begin bad++; $display("FAIL ovr_lat3 got=%0d exp=15", fr_lat[3]); end
    total++; if (idle_at !== 16) begin bad++; $display("FAIL ovr_frame_len got=%0d exp=16", idle_at); end
    // Phase 0x100000 + 0x300000 = 0x400000 -> 0x3FF
    run_frame(-1);
    total++; if (fr_data[3] !== 12'h3FF) begin bad++; $display("FAIL ovr_ch3_f2 got=%h exp=3ff", fr_data[3]); end
    total++; if (fr_data[0] !== 12'h1FF) begin bad++; $display("FAIL ovr_ch0_f2 got=%h exp=1ff", fr_data[0]); end
  endtask

  task automatic test_commit_edge();
    apply_reset();
    cfg_write(2'd0, 2'd0, 24'h100000);
    cfg_write(2'd0, 2'd1, 24'h000FFF);
    inj_ch = 2'd0; inj_addr = 2'd0; inj_data = 24'h200000;
    run_frame(0);
    total++; if (fr_data[0] !== 12'h0FF) begin bad++; $display("FAIL edge_f1 got=%h exp=0ff", fr_data[0]); end
    // Phase 0x100000 + 0x200000 = 0x300000 -> 0x2FF
    run_frame(-1);
    total++; if (fr_data[0] !== 12'h2FF) begin bad++; $display("FAIL edge_f2 got=%h exp=2ff", fr_data[0]); end
  endtask

  task automatic test_offset();
    logic [11:0] exp_hi, exp_lo;
`ifdef DDS_OFFSET_EN
    exp_hi = 12'hFFF; exp_lo = 12'h300;
`else
    exp_hi = 12'h200; exp_lo = 12'h200;
`endif
    // Saw phase 0x400000 -> 0x400 * 0x800 >> 12 = 0x200
    apply_reset();
    cfg_write(2'd0, 2'd0, 24'h400000);
    cfg_write(2'd0, 2'd1, 24'h000800);
    cfg_write(2'd0, 2'd3, 24'h000F00);
    run_frame(-1);
    total++; if (fr_data[0] !== exp_hi) begin bad++; $display("FAIL off_sat got=%h exp=%h", fr_data[0], exp_hi); end
    apply_reset();
    cfg_write(2'd0, 2'd0, 24'h400000);
    cfg_write(2'd0, 2'd1, 24'h000800);
    cfg_write(2'd0, 2'd3, 24'h000100);
    run_frame(-1);
    total++; if (fr_data[0] !== exp_lo) begin bad++; $display("FAIL off_add got=%h exp=%h", fr_data[0], exp_lo); end
  endtask

  initial begin
    rst = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0;
    cfg_data = '0; out_ready = 1'b1;
    inj_ch = '0; inj_addr = '0; inj_data = '0;
    test_reset();
    test_saw();
    test_square();
    test_shapes();
    test_backpressure();
    test_overrun();
    test_commit_edge();
    test_offset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
